hilo_div: RTL and testbench

HILO_DIV -- requirements
Module: hilo_div

---
 rtl/hilo_div_pkg.sv | 30 +++
 rtl/hilo_div_step.sv | 29 ++
 rtl/hilo_div.sv | 104 ++++++++++
 tb/tb_hilo_div.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hilo_div_pkg.sv
// Shared widths, state encodings and handshake constants for the HI/LO divider.
package hilo_div_pkg;

   localparam int REG_W  = 32;
   localparam int DREG_W = 64;
   localparam int CNT_W  = 6;

   localparam logic [REG_W-1:0]  ZERO_WORD   = '0;
   localparam logic [DREG_W-1:0] ZERO_DWORD  = '0;
   localparam logic [CNT_W-1:0]  LAST_CNT    = 6'd32;

   localparam logic RST_ENABLE           = 1'b1;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   typedef enum logic [1:0] {
      ST_FREE    = 2'b00,
      ST_BY_ZERO = 2'b01,
      ST_ON      = 2'b10,
      ST_END     = 2'b11
   } div_state_t;

   // Two's-complement negate when en is set; used for both abs() and sign fix-up.
   function automatic logic [REG_W-1:0] cond_neg(input logic [REG_W-1:0] v, input logic en);
      return en ? (ZERO_WORD - v) : v;
   endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring divide step: shift in the next dividend bit, trial-subtract, select.
module hilo_div_step
   import hilo_div_pkg::*;
(
   input  logic [REG_W-1:0] rem,
   input  logic [REG_W-1:0] quo,
   input  logic [REG_W-1:0] divisor,
   output logic [REG_W-1:0] rem_nxt,
   output logic [REG_W-1:0] quo_nxt
);

   logic [REG_W:0] partial;
   logic [REG_W:0] diff;

   // quo doubles as the dividend shift register: its MSB feeds the partial remainder
   // while the new quotient bit enters at the LSB.
   always_comb begin
      partial = {rem, quo[REG_W-1]};
      diff    = partial - {1'b0, divisor};
      if (diff[REG_W]) begin
         rem_nxt = partial[REG_W-1:0];
         quo_nxt = {quo[REG_W-2:0], 1'b0};
      end else begin
         rem_nxt = diff[REG_W-1:0];
         quo_nxt = {quo[REG_W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/hilo_div.sv
// Multi-cycle 32-bit signed/unsigned divider producing {remainder, quotient} for the HI/LO port.
module hilo_div
   import hilo_div_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              annul_i,
   input  logic              signed_div_i,
   input  logic [REG_W-1:0]  opdata1_i,
   input  logic [REG_W-1:0]  opdata2_i,
   output logic [DREG_W-1:0] result_o,
   output logic              ready_o
);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [REG_W-1:0] divisor;
   logic [REG_W-1:0] rem;
   logic [REG_W-1:0] quo;
   logic             neg_q;
   logic             neg_r;
   logic [REG_W-1:0] rem_nxt;
   logic [REG_W-1:0] quo_nxt;

   hilo_div_step u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state    <= ST_FREE;
         cnt      <= '0;
         divisor  <= ZERO_WORD;
         rem      <= ZERO_WORD;
         quo      <= ZERO_WORD;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= ZERO_DWORD;
         ready_o  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            ST_FREE: begin
               result_o <= ZERO_DWORD;
               ready_o  <= DIV_RESULT_NOT_READY;
               if (start_i == DIV_START && !annul_i) begin
                  // Operands are stored as magnitudes; only the fix-up flags remember the signs.
                  divisor <= cond_neg(opdata2_i, signed_div_i & opdata2_i[REG_W-1]);
                  quo     <= cond_neg(opdata1_i, signed_div_i & opdata1_i[REG_W-1]);
                  rem     <= ZERO_WORD;
                  neg_q   <= signed_div_i & (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
                  neg_r   <= signed_div_i & opdata1_i[REG_W-1];
                  cnt     <= '0;
                  state   <= (opdata2_i == ZERO_WORD) ? ST_BY_ZERO : ST_ON;
               end
            end

            // Divide-by-zero reports an all-zero result; ready rises on the first END edge.
            ST_BY_ZERO: begin
               result_o <= ZERO_DWORD;
               ready_o  <= DIV_RESULT_NOT_READY;
               state    <= annul_i ? ST_FREE : ST_END;
            end

            ST_ON: begin
               if (annul_i) begin
                  cnt   <= '0;
                  state <= ST_FREE;
               end else if (cnt != LAST_CNT) begin
                  rem <= rem_nxt;
                  quo <= quo_nxt;
                  cnt <= cnt + 1'b1;
               end else begin
                  result_o <= {cond_neg(rem, neg_r), cond_neg(quo, neg_q)};
                  ready_o  <= DIV_RESULT_READY;
                  cnt      <= '0;
                  state    <= ST_END;
               end
            end

            ST_END: begin
               if (start_i == DIV_STOP) begin
                  result_o <= ZERO_DWORD;
                  ready_o  <= DIV_RESULT_NOT_READY;
                  state    <= ST_FREE;
               end else begin
                  ready_o  <= DIV_RESULT_READY;
               end
            end

            default: begin
               result_o <= ZERO_DWORD;
               ready_o  <= DIV_RESULT_NOT_READY;
               state    <= ST_FREE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_div.sv
// Directed bench for hilo_div: latency, signed/unsigned results, divide-by-zero, annul and reset.
module tb_hilo_div;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_chk;
   int n_fail;

   hilo_div dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Start held throughout; operands scrambled after acceptance to prove they were latched.
   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int lat);
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b0;
      opdata1_i = a; opdata2_i = b; signed_div_i = sgn;
      @(posedge clk);
      @(negedge clk);
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
      repeat (lat - 1) @(posedge clk);
      #1 chk({tag, "_early"}, 64'(ready_o), 64'd0);
      @(posedge clk);
      #1 chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
      chk({tag, "_res"}, result_o, exp);
      @(posedge clk);
      #1 chk({tag, "_hold"}, result_o, exp);
      @(negedge clk) start_i = 1'b0;
      @(posedge clk);
      #1 chk({tag, "_rel_rdy"}, 64'(ready_o), 64'd0);
      chk({tag, "_rel_res"}, result_o, 64'd0);
   endtask

   task automatic watch_no_ready(input string tag, input int edges);
      logic seen;
      seen = 1'b0;
      repeat (edges) begin
         @(posedge clk);
         #1 if (ready_o) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      #1 chk("rst_rdy", 64'(ready_o), 64'd0);
      chk("rst_res", result_o, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      do_div("u100_7",  32'd100,        32'd7,        1'b0, {32'h00000002, 32'h0000000E}, 33);
      do_div("s-7_2",   32'hFFFFFFF9,   32'd2,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
      do_div("s_min_m1",32'h80000000,   32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33);
      do_div("s7_-2",   32'd7,          32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33);
      do_div("s-8_-3",  32'hFFFFFFF8,   32'hFFFFFFFD, 1'b1, {32'hFFFFFFFE, 32'h00000002}, 33);
      do_div("u_max_1", 32'hFFFFFFFF,   32'd1,        1'b0, {32'h00000000, 32'hFFFFFFFF}, 33);
      do_div("u5_10",   32'd5,          32'd10,       1'b0, {32'h00000005, 32'h00000000}, 33);
      do_div("u_m7_2",  32'hFFFFFFF9,   32'd2,        1'b0, {32'h00000001, 32'h7FFFFFFC}, 33);
      do_div("div0",    32'd1234,       32'd0,        1'b0, 64'd0, 2);

      // Annul at count 10 of an in-flight divide.
      @(negedge clk);
      start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd3; signed_div_i = 1'b0;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk) begin annul_i = 1'b1; start_i = 1'b0; end
      @(negedge clk) annul_i = 1'b0;
      watch_no_ready("annul_on_noready", 40);
      do_div("post_annul_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

      // Annul in FREE must hold off acceptance until it drops.
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3; signed_div_i = 1'b0;
      watch_no_ready("annul_free_noready", 6);
      do_div("annul_free_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);

      // Annul in BY_ZERO.
      @(negedge clk);
      start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
      @(posedge clk);
      @(negedge clk) begin annul_i = 1'b1; start_i = 1'b0; end
      @(negedge clk) annul_i = 1'b0;
      watch_no_ready("annul_byzero_noready", 5);

      // Asynchronous reset between edges, mid-ON.
      @(negedge clk);
      start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd7; signed_div_i = 1'b0;
      @(posedge clk);
      repeat (15) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid_on_rdy", 64'(ready_o), 64'd0);
      chk("rst_mid_on_res", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk) rst = 1'b0;
      do_div("post_rst_15_4", 32'd15, 32'd4, 1'b0, {32'd3, 32'd3}, 33);

      // Asynchronous reset while a result is presented in END.
      @(negedge clk);
      start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
      @(posedge clk);
      repeat (33) @(posedge clk);
      #1 chk("end_before_rst_rdy", 64'(ready_o), 64'd1);
      #2 rst = 1'b1;
      #1 chk("rst_in_end_rdy", 64'(ready_o), 64'd0);
      chk("rst_in_end_res", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk) rst = 1'b0;
      watch_no_ready("post_rst_idle", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
